led_debug_pager: RTL and testbench

Parametrised debug status pager for the board LEDs, running in the ULPI 60 MHz domain. It takes N_CH status words from asynchronous or foreign-domain sources and synchronises them. It then drives one word at a time onto the LED bank, using one of four modes: auto-rotate, manual select, sticky capture, or freeze. It replaces the hand-coded LED rotation at top level and carries its own reset synchroniser.

---
 rtl/led_debug_pager_pkg.sv | 19 +
 rtl/led_debug_pager_sync_ff.sv | 29 ++
 rtl/led_debug_pager.sv | 145 ++++++++++++++
 tb/tb_led_debug_pager.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_debug_pager_pkg.sv
`default_nettype none
// ============================================================================
// led_debug_pager_pkg : mode encodings and index-flash fraction for the pager
// Revision: 1.0
// ============================================================================
package led_debug_pager_pkg;

    typedef enum logic [1:0] {
        LP_MODE_AUTO   = 2'd0,
        LP_MODE_MANUAL = 2'd1,
        LP_MODE_STICKY = 2'd2,
        LP_MODE_FREEZE = 2'd3
    } lp_mode_e;

    // Top counter bits that must be zero for the index flash: 3 bits = 1/8 page
    localparam int LP_FLASH_BITS = 3;

endpackage
`default_nettype wire

// File: rtl/led_debug_pager_sync_ff.sv
`default_nettype none
// ============================================================================
// sync_ff : multi-stage flop synchroniser, async active-low reset to 0
// Revision: 1.0
// ============================================================================
module sync_ff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             CLK_60M,
    input  logic             NRST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sh;

    always_ff @(posedge CLK_60M or negedge NRST) begin
        if (!NRST) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[STAGES-2:0], D};
        end
    end

    assign Q = r_sh[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/led_debug_pager.sv
`default_nettype none
// ============================================================================
// led_debug_pager : pages N_CH synchronised status words onto the LED bank
// Revision: 1.0
// ============================================================================
module led_debug_pager
    import led_debug_pager_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 8,
    parameter int DWELL_LOG2  = 26,
    parameter int SYNC_STAGES = 2,
    parameter int INVERT      = 1,
    parameter int IDX_FLASH   = 1
) (
    input  logic                  CLK_60M,
    input  logic                  NRST,
    input  logic [N_CH*WIDTH-1:0] CH_DATA,
    input  logic [1:0]            MODE,
    input  logic [3:0]            SEL,
    input  logic                  CLR,
    output logic [WIDTH-1:0]      LED,
    output logic [3:0]            CUR_CH,
    output logic                  PAGE_TICK
);

    localparam logic [3:0]       c_last_ch = 4'(N_CH - 1);
    localparam logic [WIDTH-1:0] c_led_pol = (INVERT != 0) ? '1 : '0;

    logic                  w_rst_n;
    logic [N_CH*WIDTH-1:0] w_data_s;
    logic [6:0]            w_ctrl_s;
    lp_mode_e              w_mode_s;
    logic [3:0]            w_sel_s;
    logic                  w_clr_s;

    logic [DWELL_LOG2-1:0] r_cnt;
    logic                  r_tick;
    logic [3:0]            r_cur_ch;
    logic [N_CH*WIDTH-1:0] r_sticky;
    logic                  r_clr_d;
    logic [WIDTH-1:0]      r_word;

    logic                  w_wrap;
    logic                  w_clr_rise;
    logic                  w_flash;
    logic [3:0]            w_next_ch;
    logic [WIDTH-1:0]      w_word;
    logic [WIDTH-1:0]      w_onehot;
    logic [N_CH*WIDTH-1:0] w_sticky_next;

    // Reset asserts asynchronously but releases two edges after NRST rises
    sync_ff #(.WIDTH(1), .STAGES(2)) u_rst_sync (
        .CLK_60M (CLK_60M),
        .NRST    (NRST),
        .D       (1'b1),
        .Q       (w_rst_n)
    );

    sync_ff #(.WIDTH(N_CH*WIDTH), .STAGES(SYNC_STAGES)) u_data_sync (
        .CLK_60M (CLK_60M),
        .NRST    (w_rst_n),
        .D       (CH_DATA),
        .Q       (w_data_s)
    );

    sync_ff #(.WIDTH(7), .STAGES(SYNC_STAGES)) u_ctrl_sync (
        .CLK_60M (CLK_60M),
        .NRST    (w_rst_n),
        .D       ({MODE, SEL, CLR}),
        .Q       (w_ctrl_s)
    );

    assign w_mode_s   = lp_mode_e'(w_ctrl_s[6:5]);
    assign w_sel_s    = w_ctrl_s[4:1];
    assign w_clr_s    = w_ctrl_s[0];

    assign w_wrap     = &r_cnt;
    assign w_clr_rise = w_clr_s & ~r_clr_d;
    assign w_flash    = (IDX_FLASH != 0) &&
                        (r_cnt[DWELL_LOG2-1 -: LP_FLASH_BITS] == '0);

    // A clear edge reloads with the current data so a same-cycle event survives
    assign w_sticky_next = w_clr_rise ? w_data_s : (r_sticky | w_data_s);

    always_comb begin
        w_next_ch = r_cur_ch;
        case (w_mode_s)
            LP_MODE_MANUAL: begin
                w_next_ch = (32'(w_sel_s) >= N_CH) ? c_last_ch : w_sel_s;
            end
            LP_MODE_AUTO, LP_MODE_STICKY: begin
                if (w_wrap) begin
                    w_next_ch = (r_cur_ch == c_last_ch) ? 4'd0 : r_cur_ch + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_cur_ch == 4'(c)) begin
                w_word = (w_mode_s == LP_MODE_STICKY) ? r_sticky[c*WIDTH +: WIDTH]
                                                      : w_data_s[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_onehot[b] = ((32'(r_cur_ch) % WIDTH) == b);
        end
    end

    always_ff @(posedge CLK_60M or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_cur_ch <= '0;
            r_sticky <= '0;
            r_clr_d  <= 1'b0;
            r_word   <= '0;
        end else begin
            r_clr_d <= w_clr_s;
            if (w_mode_s != LP_MODE_FREEZE) begin
                r_cnt    <= r_cnt + DWELL_LOG2'(1);
                r_tick   <= w_wrap;
                r_cur_ch <= w_next_ch;
                r_sticky <= w_sticky_next;
                r_word   <= w_flash ? w_onehot : w_word;
            end else begin
                r_tick   <= 1'b0;
            end
        end
    end

    assign LED       = r_word ^ c_led_pol;
    assign CUR_CH    = r_cur_ch;
    assign PAGE_TICK = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_debug_pager.sv
`default_nettype none
// ============================================================================
// tb_led_debug_pager : randomised bench against a behavioural pager model
// Revision: 1.0
// ============================================================================
module tb_led_debug_pager;

    localparam int N_CH        = 3;
    localparam int WIDTH       = 8;
    localparam int DWELL_LOG2  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int INVERT      = 1;
    localparam int IDX_FLASH   = 1;
    localparam int PAGE        = 1 << DWELL_LOG2;
    localparam int FLASH_LEN   = PAGE / 8;

    logic                  CLK_60M = 1'b0;
    logic                  NRST    = 1'b0;
    logic [N_CH*WIDTH-1:0] CH_DATA = '0;
    logic [1:0]            MODE    = 2'd0;
    logic [3:0]            SEL     = 4'd0;
    logic                  CLR     = 1'b0;
    logic [WIDTH-1:0]      LED;
    logic [3:0]            CUR_CH;
    logic                  PAGE_TICK;

    always #8 CLK_60M = ~CLK_60M;

    led_debug_pager #(
        .N_CH        (N_CH),
        .WIDTH       (WIDTH),
        .DWELL_LOG2  (DWELL_LOG2),
        .SYNC_STAGES (SYNC_STAGES),
        .INVERT      (INVERT),
        .IDX_FLASH   (IDX_FLASH)
    ) dut (
        .CLK_60M   (CLK_60M),
        .NRST      (NRST),
        .CH_DATA   (CH_DATA),
        .MODE      (MODE),
        .SEL       (SEL),
        .CLR       (CLR),
        .LED       (LED),
        .CUR_CH    (CUR_CH),
        .PAGE_TICK (PAGE_TICK)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model: inputs seen through a delay line, page position as a number
    typedef struct packed {
        logic [1:0]            mode;
        logic [3:0]            sel;
        logic                  clr;
        logic [N_CH*WIDTH-1:0] data;
    } smp_t;

    smp_t dly[$];
    int   rel_cnt;
    int   phase;
    int   m_ch;
    int   m_led;
    int   m_tick;
    int   sticky[N_CH];
    bit   prev_clr;

    task automatic model_reset();
        dly.delete();
        for (int i = 0; i < SYNC_STAGES; i++) dly.push_back('0);
        rel_cnt  = 0;
        phase    = 0;
        m_ch     = 0;
        m_led    = (INVERT != 0) ? 'hFF : 0;
        m_tick   = 0;
        prev_clr = 0;
        for (int c = 0; c < N_CH; c++) sticky[c] = 0;
    endtask

    task automatic model_step();
        smp_t s;
        smp_t now;
        int   d[N_CH];
        int   word;
        bit   rise;
        now.mode = MODE; now.sel = SEL; now.clr = CLR; now.data = CH_DATA;
        s = dly.pop_front();
        dly.push_back(now);
        for (int c = 0; c < N_CH; c++) d[c] = int'(s.data[c*WIDTH +: WIDTH]);
        rise     = s.clr && !prev_clr;
        prev_clr = s.clr;
        if (s.mode != 2'd3) begin
            if (IDX_FLASH != 0 && phase < FLASH_LEN) word = 1 << (m_ch % WIDTH);
            else if (s.mode == 2'd2)                 word = sticky[m_ch];
            else                                     word = d[m_ch];
            m_led  = ((INVERT != 0) ? ~word : word) & 'hFF;
            m_tick = (phase == PAGE - 1) ? 1 : 0;
            phase  = (phase + 1) % PAGE;
            if (s.mode == 2'd1)  m_ch = (int'(s.sel) >= N_CH) ? N_CH - 1 : int'(s.sel);
            else if (m_tick != 0) m_ch = (m_ch + 1) % N_CH;
            for (int c = 0; c < N_CH; c++) sticky[c] = rise ? d[c] : (sticky[c] | d[c]);
        end else begin
            m_tick = 0;
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge
    task automatic tick_cycle();
        @(posedge CLK_60M);
        if (NRST) begin
            if (rel_cnt < 2) rel_cnt++;
            else             model_step();
        end
        @(negedge CLK_60M);
        check_eq("LED", LED, m_led);
        check_eq("CUR_CH", CUR_CH, m_ch);
        check_eq("PAGE_TICK", PAGE_TICK, m_tick);
    endtask

    task automatic pulse_reset();
        #3 NRST = 1'b0;
        model_reset();
        #1;
        check_eq("rst LED", LED, 'hFF);
        check_eq("rst CUR_CH", CUR_CH, 0);
        check_eq("rst PAGE_TICK", PAGE_TICK, 0);
        tick_cycle();
        tick_cycle();
        NRST = 1'b1;
    endtask

    initial begin
        model_reset();
        CH_DATA = 24'h332211;
        @(negedge CLK_60M);
        repeat (3) tick_cycle();
        NRST = 1'b1;

        repeat (60) tick_cycle();

        MODE = 2'd1; SEL = 4'd7;
        repeat (3) tick_cycle();
        check_eq("manual clamp", CUR_CH, 2);
        repeat (10) tick_cycle();
        MODE = 2'd0;
        repeat (40) tick_cycle();

        pulse_reset();
        repeat (30) tick_cycle();

        MODE = 2'd2; CH_DATA = 24'h332200;
        repeat (4) tick_cycle();
        CH_DATA[7:0] = 8'h80; tick_cycle();
        CH_DATA[7:0] = 8'h01; repeat (40) tick_cycle();
        CH_DATA[7:0] = 8'h04; CLR = 1'b1; tick_cycle();
        CH_DATA[7:0] = 8'h00; repeat (50) tick_cycle();
        CLR = 1'b0;

        repeat (200) begin
            for (int c = 0; c < N_CH; c++)
                CH_DATA[c*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ?
                                            8'(1 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 19) == 0) CLR = ~CLR;
            tick_cycle();
        end

        MODE = 2'd3;
        repeat (100) begin
            CH_DATA = 24'($urandom);
            tick_cycle();
        end
        MODE = 2'd0;
        repeat (40) tick_cycle();

        repeat (1500) begin
            if ($urandom_range(0, 49) == 0) MODE = 2'($urandom);
            if ($urandom_range(0, 3) == 0)  SEL  = 4'($urandom);
            if ($urandom_range(0, 9) == 0)  CLR  = ~CLR;
            CH_DATA = 24'($urandom);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            tick_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
